text_line_scheduler: RTL and testbench
======================================

Name: text_line_scheduler

Overview:
- Owns a one-line text buffer, fills it from a keystroke stream through a valid/ready handshake, and sequences the 5x8 character font ROM (select in, 40-bit glyph out) to produce a per-pixel text overlay for the VGA path.
- Sits between the PS/2 decode logic (ASCII producer) and the VGA pixel mux.
- The font ROM stays combinational and external; this block drives its select and consumes its glyph vector.

Parameters:
- N_CHARS, 16, character cells in the line (2..64).
- X_ORIGIN, 64, first pixel column of cell 0.
- Y_ORIGIN, 64, first pixel row of the line.
- BLINK_DIV, 25000000, clk cycles per cursor blink half-period (used only with the optional feature).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- hc  in  11  current horizontal pixel coordinate.
- vc  in  11  current vertical pixel coordinate.
- char_in  in  8  ASCII code from keyboard decoder.
- char_valid  in  1  char_in valid.
- char_ready  out  1  block accepts char_in this cycle.
- clear  in  1  one-cycle pulse: blank the whole line.
- font_sel  out  8  ASCII code to font ROM select.
- font_vec  in  40  glyph from font ROM; row r = bits [5r+4:5r], row 0 top, bit 5r+0 leftmost column.
- pix_on  out  1  text pixel lit.
- cursor_pos  out  6  current write pointer.

Behaviour:
- Reset, asynchronous and active-low:
  - all buffer entries = 8'd32 (space); wr_ptr = 0; state = IDLE.
  - font_sel = 8'd32; pix_on = 0; pipeline valid bits = 0.
  - char_ready = 0 while rst_n is low.
- FSM states:
  - IDLE: normal operation.
  - CLEAR: writes space to entry clr_idx, one entry per cycle, clr_idx 0..N_CHARS-1 (N_CHARS cycles). Sets wr_ptr = 0 on the final write, then returns to IDLE.
- char_ready = (state == IDLE) && !clear. A transfer occurs on char_valid && char_ready.
- clear in IDLE → CLEAR next cycle. clear in CLEAR is ignored (no restart). If clear and char_valid coincide, clear wins and no char is accepted.
- Accepted char, by code:
  - 8'h08 (backspace): if wr_ptr > 0, wr_ptr decrements and entry[wr_ptr-1] = space. At wr_ptr = 0 there is no change.
  - 8'h0D (enter): treated as clear; → CLEAR.
  - Any other code: entry[wr_ptr] = char_in. wr_ptr increments if wr_ptr < N_CHARS-1. At N_CHARS-1 it stays, so later chars overwrite the last cell. There is no wrap.
- cursor_pos = wr_ptr, registered.
- Render pipeline, fixed 2-cycle latency; pix_on at cycle t+2 reflects hc/vc sampled at cycle t.
  - Stage 0, combinational: dx = hc - X_ORIGIN, dy = vc - Y_ORIGIN, in_win = (hc >= X_ORIGIN) && (dx < 6*N_CHARS) && (vc >= Y_ORIGIN) && (dy < 8). Each cell is 6 pixels wide: idx = dx/6, col = dx%6.
  - Stage 1, registered: font_sel <= in_win ? entry[idx] : 8'd32. col_d, row_d = dy[2:0], idx_d and in_win_d are also registered.
  - Stage 2, registered: pix_on <= in_win_d && (col_d < 5) && font_vec[5*row_d + col_d]. Column 5 is the inter-character gap and is always 0.
- A buffer write and a stage-1 read of the same entry in the same cycle: the read returns the old value.
- Codes the ROM maps to its default glyph are stored unmodified; rendering shows whatever the ROM returns.
- Reset mid-CLEAR or mid-frame aborts immediately into the reset state; no partial state is retained.

Optional Feature:
- Macro: TEXT_CURSOR_BLINK_EN.
- Defined:
  - A free-running counter toggles blink_ph every BLINK_DIV cycles; reset value 0, cursor visible.
  - Stage 2 ORs in cursor_pix = in_win_d && (idx_d == wr_ptr) && (row_d == 7) && (col_d < 5) && !blink_ph.
- Not defined: no counter is instantiated, BLINK_DIV is unused, and pix_on is glyph-only.

Test Plan:
- Reset, then sweep hc over the window at vc = Y_ORIGIN → pix_on = 0 everywhere; char_ready = 1 one cycle after rst_n rises; cursor_pos = 0.
- Send "1" (8'h31) → entry0 = 8'h31, cursor_pos = 1. At vc = Y_ORIGIN, hc = X_ORIGIN+2: font_sel = 8'h31 after 1 cycle; pix_on = 1 after 2 cycles (top row 00100, col 2). At hc = X_ORIGIN+5: pix_on = 0 (gap).
- Send N_CHARS+3 chars "a" then "b" → cursor_pos saturates at 15 (N_CHARS = 16); entry15 = "b"; entries 0..14 unchanged.
- Backspace at cursor_pos = 3 → cursor_pos = 2, entry2 = 8'd32. Backspace at cursor_pos = 0 → no change.
- Pulse clear with char_valid = 1 in the same cycle → char not accepted; char_ready = 0 for 16 cycles; then all entries = space, cursor_pos = 0. A second clear during CLEAR does not extend it.
- With TEXT_CURSOR_BLINK_EN and BLINK_DIV = 4: at cursor cell row 7 cols 0..4, pix_on alternates 1/0 every 4 cycles. Without the macro, pix_on = 0 there.

Source files
------------

// File: rtl/text_line_scheduler_if.sv
// Keystroke handshake between the PS/2 ASCII decoder (master) and the
// text line scheduler (slave).
interface text_line_scheduler_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;

    modport master (output char_in, output char_valid, input char_ready);
    modport slave  (input char_in, input char_valid, output char_ready);
endinterface

// File: rtl/text_line_scheduler.sv
// One-line text buffer fed by keystrokes, rendered through an external 5x8 font ROM
// with a fixed 2-cycle pixel pipeline. Optional blinking cursor: TEXT_CURSOR_BLINK_EN.
module text_line_scheduler #(
    parameter int N_CHARS   = 16,
    parameter int X_ORIGIN  = 64,
    parameter int Y_ORIGIN  = 64,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [10:0]             hc,
    input  logic [10:0]             vc,
    text_line_scheduler_if.slave    key,
    input  logic                    clear,
    output logic [7:0]              font_sel,
    input  logic [39:0]             font_vec,
    output logic                    pix_on,
    output logic [5:0]              cursor_pos
);
    localparam int         IDX_W  = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
    localparam logic [5:0] LAST   = 6'(N_CHARS - 1);
    localparam logic [7:0] SPACE  = 8'd32;
    localparam logic [10:0] WIN_W = 11'(6 * N_CHARS);

    typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

    state_t     state_q, state_d;
    logic [5:0] wr_ptr_q, wr_ptr_d;
    logic [5:0] clr_idx_q, clr_idx_d;
    logic       ready_q, ready_d;
    logic [7:0] buf_q [N_CHARS];
    logic [7:0] buf_d [N_CHARS];
    logic [7:0] font_sel_q, font_sel_d;
    logic [2:0] col_q, col_d, row_q, row_d;
    logic       in_win_q, in_win_d;
    logic       pix_q, pix_d;

    logic [10:0]      dx_s, dy_s;
    logic             in_win_s;
    logic [IDX_W-1:0] idx_s;
    logic [2:0]       col_s;
    logic [5:0]       bit_idx_s;
    logic             glyph_bit_s;
    logic             cursor_pix_s;
    logic             accept_s;

    // Ready is held low through reset and one cycle after, and drops whenever clear is asserted.
    assign key.char_ready = ready_q && (state_q == ST_IDLE) && !clear;
    assign accept_s       = key.char_valid && key.char_ready;
    assign cursor_pos     = wr_ptr_q;
    assign font_sel       = font_sel_q;
    assign pix_on         = pix_q;

    assign dx_s     = hc - 11'(X_ORIGIN);
    assign dy_s     = vc - 11'(Y_ORIGIN);
    assign in_win_s = (hc >= 11'(X_ORIGIN)) && (dx_s < WIN_W) &&
                      (vc >= 11'(Y_ORIGIN)) && (dy_s < 11'd8);
    assign idx_s    = IDX_W'(dx_s / 11'd6);
    assign col_s    = 3'(dx_s % 11'd6);

    // Buffer edits and line-clear sequencing.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        clr_idx_d = clr_idx_q;
        buf_d     = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = 6'd0;
                end else if (accept_s) begin
                    case (key.char_in)
                        8'h08: begin
                            if (wr_ptr_q != 6'd0) begin
                                wr_ptr_d = wr_ptr_q - 6'd1;
                                buf_d[IDX_W'(wr_ptr_q - 6'd1)] = SPACE;
                            end else begin
                                wr_ptr_d = wr_ptr_q;
                            end
                        end
                        8'h0D: begin
                            state_d   = ST_CLEAR;
                            clr_idx_d = 6'd0;
                        end
                        default: begin
                            buf_d[wr_ptr_q[IDX_W-1:0]] = key.char_in;
                            wr_ptr_d = (wr_ptr_q < LAST) ? wr_ptr_q + 6'd1 : wr_ptr_q;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                buf_d[clr_idx_q[IDX_W-1:0]] = SPACE;
                if (clr_idx_q == LAST) begin
                    wr_ptr_d  = 6'd0;
                    clr_idx_d = 6'd0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + 6'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Stage 1 reads the buffer before this cycle's write lands, so a same-cycle read sees the old code.
    always_comb begin
        font_sel_d = in_win_s ? buf_q[idx_s] : SPACE;
        col_d      = col_s;
        row_d      = dy_s[2:0];
        in_win_d   = in_win_s;
    end

    assign bit_idx_s   = ({3'd0, row_q} * 6'd5) + {3'd0, col_q};
    assign glyph_bit_s = (col_q < 3'd5) ? font_vec[bit_idx_s] : 1'b0;

`ifdef TEXT_CURSOR_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic [5:0]    idx_q, idx_d;

    // Blink phase flips each time the divider wraps; phase 0 shows the underline.
    always_comb begin
        if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_ph_d  = !blink_ph_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            blink_ph_d  = blink_ph_q;
        end
        idx_d = 6'(idx_s);
    end

    // Blink divider and cell index alongside stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            idx_q       <= 6'd0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            idx_q       <= idx_d;
        end
    end

    assign cursor_pix_s = in_win_q && (idx_q == wr_ptr_q) && (row_q == 3'd7) &&
                          (col_q < 3'd5) && !blink_ph_q;
`else
    logic unused_blink_s;
    assign unused_blink_s = (BLINK_DIV > 0);
    assign cursor_pix_s   = 1'b0;
`endif

    assign pix_d = (in_win_q && glyph_bit_s) || cursor_pix_s;

    // Control state, text buffer and render pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= 6'd0;
            clr_idx_q  <= 6'd0;
            ready_q    <= 1'b0;
            for (int i = 0; i < N_CHARS; i++) buf_q[i] <= SPACE;
            font_sel_q <= SPACE;
            col_q      <= 3'd0;
            row_q      <= 3'd0;
            in_win_q   <= 1'b0;
            pix_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            clr_idx_q  <= clr_idx_d;
            ready_q    <= ready_d;
            for (int i = 0; i < N_CHARS; i++) buf_q[i] <= buf_d[i];
            font_sel_q <= font_sel_d;
            col_q      <= col_d;
            row_q      <= row_d;
            in_win_q   <= in_win_d;
            pix_q      <= pix_d;
        end
    end
endmodule

// File: tb/tb_text_line_scheduler.sv
// Directed bench for text_line_scheduler with a small behavioural font ROM.
module tb_text_line_scheduler;
    localparam int N  = 16;
    localparam int X0 = 64;
    localparam int Y0 = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hc, vc;
    logic        clear;
    logic [7:0]  font_sel;
    logic [39:0] font_vec;
    logic        pix_on;
    logic [5:0]  cursor_pos;

    int n_vec = 0;
    int n_err = 0;

    text_line_scheduler_if kif ();

    text_line_scheduler #(.N_CHARS(N), .X_ORIGIN(X0), .Y_ORIGIN(Y0), .BLINK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc), .key(kif.slave), .clear(clear),
        .font_sel(font_sel), .font_vec(font_vec), .pix_on(pix_on), .cursor_pos(cursor_pos)
    );

    always #5 clk = ~clk;

    // '1' is a vertical bar in column 2, space is blank, other codes light columns from their low bits.
    function automatic logic [39:0] font_rom(input logic [7:0] s);
        if (s == 8'h31) return {8{5'b00100}};
        else if (s == 8'h20) return 40'd0;
        else return {8{s[4:0]}};
    endfunction

    assign font_vec = font_rom(font_sel);

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!kif.char_ready && w < 40) begin
            tick();
            w++;
        end
        check_eq("ready_wait", 64'(w < 40), 64'd1);
    endtask

    task automatic send(input logic [7:0] c);
        wait_ready();
        kif.char_in    = c;
        kif.char_valid = 1'b1;
        tick();
        kif.char_valid = 1'b0;
    endtask

    task automatic chk_entry(input int i, input logic [7:0] exp);
        hc = 11'(X0 + 6 * i);
        vc = 11'(Y0);
        tick();
        check_eq($sformatf("entry%0d", i), 64'(font_sel), 64'(exp));
        hc = 11'd0;
    endtask

    task automatic chk_pix(input int h, input int v, input logic exp, input string tag);
        hc = 11'(h);
        vc = 11'(v);
        tick();
        tick();
        check_eq(tag, 64'(pix_on), 64'(exp));
    endtask

    initial begin
        int ones;
        rst_n = 1'b0; hc = 11'd0; vc = 11'd0; clear = 1'b0;
        kif.char_in = 8'd0; kif.char_valid = 1'b0;
        repeat (3) tick();
        check_eq("rst_ready", 64'(kif.char_ready), 64'd0);
        check_eq("rst_pix", 64'(pix_on), 64'd0);
        check_eq("rst_font_sel", 64'(font_sel), 64'h20);
        check_eq("rst_cursor", 64'(cursor_pos), 64'd0);
        rst_n = 1'b1;
        tick();
        check_eq("ready_after_rst", 64'(kif.char_ready), 64'd1);

        vc = 11'(Y0);
        for (int h = X0 - 1; h <= X0 + 6 * N; h++) begin
            hc = 11'(h);
            tick();
            check_eq("blank_sweep", 64'(pix_on), 64'd0);
        end

        send(8'h31);
        check_eq("cursor_after_1", 64'(cursor_pos), 64'd1);
        hc = 11'(X0 + 2); vc = 11'(Y0);
        tick();
        check_eq("font_sel_1", 64'(font_sel), 64'h31);
        tick();
        check_eq("pix_1_col2", 64'(pix_on), 64'd1);
        chk_pix(X0 + 5, Y0, 1'b0, "pix_gap");
        chk_pix(X0, Y0, 1'b0, "pix_col0");
        chk_pix(X0 + 2, Y0 + 7, 1'b1, "pix_row7");
        chk_pix(X0 + 2, Y0 + 8, 1'b0, "pix_below");
        hc = 11'(X0 - 1); vc = 11'(Y0);
        tick();
        check_eq("font_sel_left_edge", 64'(font_sel), 64'h20);

        // Clear coincident with a valid char; a second clear mid-sequence must not extend it.
        hc = 11'd0;
        clear = 1'b1; kif.char_in = 8'h7A; kif.char_valid = 1'b1;
        #1;
        check_eq("ready_on_clear", 64'(kif.char_ready), 64'd0);
        tick();
        clear = 1'b0; kif.char_valid = 1'b0;
        check_eq("clr_ready0", 64'(kif.char_ready), 64'd0);
        for (int k = 1; k < 16; k++) begin
            tick();
            check_eq($sformatf("clr_ready%0d", k), 64'(kif.char_ready), 64'd0);
            if (k == 2) clear = 1'b1;
            if (k == 3) clear = 1'b0;
        end
        tick();
        check_eq("clr_ready_end", 64'(kif.char_ready), 64'd1);
        check_eq("clr_cursor", 64'(cursor_pos), 64'd0);
        chk_entry(0, 8'h20);
        chk_entry(1, 8'h20);

        repeat (N + 2) send(8'h61);
        send(8'h62);
        check_eq("sat_cursor", 64'(cursor_pos), 64'd15);
        for (int i = 0; i < N - 1; i++) chk_entry(i, 8'h61);
        chk_entry(N - 1, 8'h62);
        hc = 11'(X0 + 6 * N - 1); vc = 11'(Y0);
        tick();
        check_eq("font_sel_right_in", 64'(font_sel), 64'h62);
        hc = 11'(X0 + 6 * N);
        tick();
        check_eq("font_sel_right_out", 64'(font_sel), 64'h20);

        send(8'h0D);
        wait_ready();
        check_eq("enter_cursor", 64'(cursor_pos), 64'd0);
        hc = 11'(X0); vc = 11'(Y0);
        kif.char_in = 8'h61; kif.char_valid = 1'b1;
        tick();
        kif.char_valid = 1'b0;
        check_eq("rd_old", 64'(font_sel), 64'h20);
        check_eq("cursor_a", 64'(cursor_pos), 64'd1);
        tick();
        check_eq("rd_new", 64'(font_sel), 64'h61);
        chk_entry(N - 1, 8'h20);

        send(8'h62);
        send(8'h63);
        check_eq("cursor_abc", 64'(cursor_pos), 64'd3);
        send(8'h08);
        check_eq("bs_cursor2", 64'(cursor_pos), 64'd2);
        chk_entry(2, 8'h20);
        chk_entry(1, 8'h62);
        send(8'h08);
        send(8'h08);
        check_eq("bs_cursor0", 64'(cursor_pos), 64'd0);
        chk_entry(0, 8'h20);
        send(8'h08);
        check_eq("bs_at_zero", 64'(cursor_pos), 64'd0);

`ifdef TEXT_CURSOR_BLINK_EN
        hc = 11'(X0 + 2); vc = 11'(Y0 + 7);
        tick();
        tick();
        ones = 0;
        repeat (16) begin
            tick();
            ones += int'(pix_on);
        end
        check_eq("blink_duty", 64'(ones), 64'd8);
`else
        ones = 0;
        chk_pix(X0 + 2, Y0 + 7, 1'b0, "no_cursor_pix");
        repeat (8) begin
            tick();
            ones += int'(pix_on);
        end
        check_eq("no_cursor_hold", 64'(ones), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end
endmodule
